// File: rtl/dll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dll_pkg
// Description : Shared data link layer constants: sequence width, ACK/NAK
//               request codes and the receive ACK/NAK scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dll_pkg;

    localparam int SEQ_W = 12;

    // Request codes, shared with the replay buffer on the far side
    localparam logic [1:0] ACKNAK_NONE = 2'b00;
    localparam logic [1:0] ACKNAK_ACK  = 2'b01;
    localparam logic [1:0] ACKNAK_NAK  = 2'b10;

    // Receive ACK/NAK scheduler states
    localparam int              ST_W        = 2;
    localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [ST_W-1:0] ST_ACK_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_SEND_ACK = 2'd2;
    localparam logic [ST_W-1:0] ST_SEND_NAK = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seq_window_cmp.sv
`default_nettype none
// ============================================================================
// Module      : seq_window_cmp
// Description : Modulo-4096 sequence window compare. The received sequence is
//               in order, a duplicate (up to 2048 behind) or ahead (1..2047).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_window_cmp
    import dll_pkg::*;
(
    input  logic [SEQ_W-1:0] seq,
    input  logic [SEQ_W-1:0] next,
    output logic             in_order,
    output logic             duplicate,
    output logic             ahead
);

    // Wraparound distance; its MSB splits the window into behind/ahead halves
    logic [SEQ_W-1:0] w_dist;

    assign w_dist    = seq - next;
    assign in_order  = (w_dist == '0);
    assign duplicate = w_dist[SEQ_W-1];
    assign ahead     = (w_dist != '0) && !w_dist[SEQ_W-1];

endmodule
`default_nettype wire

// File: rtl/dll_rx_acknak.sv
`default_nettype none
// ============================================================================
// Module      : dll_rx_acknak
// Description : Receive-side DLL sequence checker and ACK/NAK scheduler.
//               Forwards in-order good TLPs, drops duplicates and bad TLPs,
//               and issues ACK/NAK requests with AckNak_Seq_Num.
// Revision    : 1.0 - initial release
// ============================================================================
module dll_rx_acknak
    import dll_pkg::*;
#(
    parameter int ACK_LAT      = 16,
    parameter int ACK_COALESCE = 4
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             tlp_valid,
    input  logic [SEQ_W-1:0] tlp_seq,
    input  logic             lcrc_ok,
    output logic             fwd_valid,
    output logic [1:0]       acknak,
    output logic [SEQ_W-1:0] ack_seq,
    input  logic             busy_n
);

    localparam int                 c_tmr_w    = (ACK_LAT > 2) ? $clog2(ACK_LAT) : 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(ACK_LAT - 1);

    logic [ST_W-1:0]    r_state, w_state_nxt;
    logic [SEQ_W-1:0]   r_next_rcv_seq;
    logic               r_nak_sched;
    logic [2:0]         r_ack_pend, w_ack_pend_nxt;
    logic [c_tmr_w-1:0] r_timer, w_timer_nxt;
    logic               r_nak_hold, w_nak_hold_nxt;
    logic               r_ack_hold, w_ack_hold_nxt;
    logic               r_fwd_valid;
    logic [1:0]         r_acknak, w_acknak_nxt;
    logic [SEQ_W-1:0]   r_ack_seq, w_ack_seq_nxt;

    logic               w_in_order, w_duplicate, w_ahead;
    logic               w_good, w_dup, w_bad, w_nak_req;
    logic               w_coalesce, w_timer_hit, w_go_nak, w_go_ack;
    logic [SEQ_W-1:0]   w_seq_upd;
    logic [2:0]         w_pend_upd;

    seq_window_cmp u_cmp (
        .seq       (tlp_seq),
        .next      (r_next_rcv_seq),
        .in_order  (w_in_order),
        .duplicate (w_duplicate),
        .ahead     (w_ahead)
    );

    // TLP classification and the post-update view of the sequence/pending count
    assign w_good      = tlp_valid && lcrc_ok && w_in_order;
    assign w_dup       = tlp_valid && lcrc_ok && w_duplicate;
    assign w_bad       = tlp_valid && (!lcrc_ok || w_ahead);
    assign w_nak_req   = w_bad && !r_nak_sched;
    assign w_seq_upd   = w_good ? (r_next_rcv_seq + SEQ_W'(1)) : r_next_rcv_seq;
    assign w_pend_upd  = (w_good && (r_ack_pend != 3'd7)) ? (r_ack_pend + 3'd1) : r_ack_pend;
    assign w_coalesce  = (int'(w_pend_upd) >= ACK_COALESCE);
    assign w_timer_hit = (r_timer == c_tmr_last);

    // Next-state and request selection; NAK always outranks any ACK cause
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_ack_pend_nxt = w_pend_upd;
        w_nak_hold_nxt = r_nak_hold;
        w_ack_hold_nxt = r_ack_hold;
        w_acknak_nxt   = r_acknak;
        w_ack_seq_nxt  = r_ack_seq;
        w_go_nak       = 1'b0;
        w_go_ack       = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACK_WAIT: begin
                if (w_nak_req) begin
                    w_go_nak = 1'b1;
                end else if (w_dup || w_coalesce || ((r_state == ST_ACK_WAIT) && w_timer_hit)) begin
                    w_go_ack = 1'b1;
                end else if (r_state == ST_ACK_WAIT) begin
                    w_timer_nxt = r_timer + c_tmr_w'(1);
                end else if (w_good) begin
                    w_state_nxt = ST_ACK_WAIT;
                    w_timer_nxt = '0;
                end
            end
            default: begin
                // Requests raised while a code is on the wire wait their turn
                w_nak_hold_nxt = r_nak_hold || w_nak_req;
                w_ack_hold_nxt = r_ack_hold || w_dup;
                if (busy_n) begin
                    if (r_nak_hold || w_nak_req) begin
                        w_go_nak = 1'b1;
                    end else if (r_ack_hold || w_dup || w_coalesce) begin
                        w_go_ack = 1'b1;
                    end else begin
                        w_acknak_nxt = ACKNAK_NONE;
                        w_timer_nxt  = '0;
                        w_state_nxt  = (w_pend_upd != 3'd0) ? ST_ACK_WAIT : ST_IDLE;
                    end
                end
            end
        endcase
        if (w_go_nak) begin
            w_state_nxt    = ST_SEND_NAK;
            w_acknak_nxt   = ACKNAK_NAK;
            w_ack_seq_nxt  = w_seq_upd - SEQ_W'(1);
            w_nak_hold_nxt = 1'b0;
        end else if (w_go_ack) begin
            // The latched ack_seq covers every TLP counted so far, so the
            // pending count restarts here; later acceptances stay pending.
            w_state_nxt    = ST_SEND_ACK;
            w_acknak_nxt   = ACKNAK_ACK;
            w_ack_seq_nxt  = w_seq_upd - SEQ_W'(1);
            w_ack_pend_nxt = 3'd0;
            w_ack_hold_nxt = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Receive tracking, timer, held requests and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_rcv_seq <= '0;
            r_nak_sched    <= 1'b0;
            r_ack_pend     <= 3'd0;
            r_timer        <= '0;
            r_nak_hold     <= 1'b0;
            r_ack_hold     <= 1'b0;
            r_fwd_valid    <= 1'b0;
            r_acknak       <= ACKNAK_NONE;
            r_ack_seq      <= '1;
        end else begin
            r_next_rcv_seq <= w_seq_upd;
            if (w_good) begin
                r_nak_sched <= 1'b0;
            end else if (w_nak_req) begin
                r_nak_sched <= 1'b1;
            end
            r_ack_pend     <= w_ack_pend_nxt;
            r_timer        <= w_timer_nxt;
            r_nak_hold     <= w_nak_hold_nxt;
            r_ack_hold     <= w_ack_hold_nxt;
            r_fwd_valid    <= w_good;
            r_acknak       <= w_acknak_nxt;
            r_ack_seq      <= w_ack_seq_nxt;
        end
    end

    assign fwd_valid = r_fwd_valid;
    assign acknak    = r_acknak;
    assign ack_seq   = r_ack_seq;

endmodule
`default_nettype wire

// File: doc/dll_rx_acknak.md
# dll_rx_acknak

Receive-side data link layer sequence checker and ACK/NAK scheduler for the PCIe link. It sits between the receive LCRC checker and the transaction layer. It tracks NEXT_RCV_SEQ, forwards in-order good TLPs, and drops duplicates and bad TLPs. It produces the ACK/NAK requests (code plus 12-bit sequence) that the far-end replay buffer consumes.

## Interface
Parameters:
- ACK_LAT, default 16: ACK latency timer limit in cycles (must be at least 2).
- ACK_COALESCE, default 4: number of accepted TLPs that forces an immediate ACK (must be at least 1).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- tlp_valid  in  1  one-cycle strobe: a received TLP's header/CRC result is present.
- tlp_seq  in  12  sequence number of the received TLP.
- lcrc_ok  in  1  LCRC check passed for this TLP.
- fwd_valid  out  1  registered one-cycle pulse: TLP accepted, pass to transaction layer.
- acknak  out  2  request code: 2'b00 none, 2'b01 ACK, 2'b10 NAK. 2'b11 is never driven.
- ack_seq  out  12  AckNak_Seq_Num accompanying acknak.
- busy_n  in  1  DLLP transmit arbiter ready. High on an edge while acknak≠0 consumes the request.

## Operation
- State registers:
  - next_rcv_seq (12b, reset 0).
  - nak_sched (reset 0).
  - ack_pend count (3b, reset 0).
  - latency timer (reset 0).
  - FSM state (reset IDLE).
- Reset values: fwd_valid=0, acknak=00, ack_seq=12'hFFF.
- TLP classification on each tlp_valid edge. d = (tlp_seq − next_rcv_seq) mod 4096, computed in 12-bit wraparound.
  - lcrc_ok && d==0 → good. Pulse fwd_valid. next_rcv_seq+1 (4095 wraps to 0). Increment ack_pend (saturating). Clear nak_sched.
  - lcrc_ok && d≥2048 (a duplicate, behind next_rcv_seq) → discard. Request an immediate ACK (dup_ack flag).
  - Otherwise (LCRC bad, or seq ahead, 1..2047) → discard. If nak_sched==0, set nak_sched and request a NAK. If nak_sched==1, drop silently.
- FSM states: IDLE, ACK_WAIT, SEND_ACK, SEND_NAK.
  - IDLE: a good TLP → ACK_WAIT with timer=0.
  - ACK_WAIT: the timer increments each cycle. Go to SEND_ACK when timer==ACK_LAT−1 or ack_pend reaches ACK_COALESCE.
  - SEND_ACK / SEND_NAK: on entry, latch ack_seq = next_rcv_seq−1, using the post-update value if a TLP is accepted on the same edge. Drive acknak at the matching code. Hold both stable until busy_n=1 at an edge.
  - After consumption: go to ACK_WAIT (timer restart) if ack_pend>0, else IDLE.
- Priority when entering a send state: NAK request > dup_ack / coalesce / timer ACK.
  - A NAK request arriving during ACK_WAIT preempts it. ack_pend is preserved.
  - A request arriving while in a send state is held and issued after consumption. NAK still wins.
- ack_pend handling:
  - Cleared when an ACK is consumed.
  - Not cleared by a NAK.
  - TLPs accepted during SEND_ACK after the ack_seq latch remain pending.
- Reset asserted mid-operation: all state returns to reset values on that edge. Any pending request is abandoned.

## Timing
- fwd_valid is asserted in the cycle after the sampling edge and lasts exactly 1 cycle.
- Bad TLP sampled at edge N from IDLE/ACK_WAIT → acknak=10 during cycle N+1.
- Duplicate TLP → acknak=01 during cycle N+1.
- Good TLP at edge N from IDLE, with no further traffic and busy_n=1 → acknak=01 appears after ACK_LAT cycles of ACK_WAIT, during cycle N+1+ACK_LAT.
- A request is consumed on the first edge with busy_n=1. acknak returns to 00 the next cycle unless a held request follows, in which case the next code appears on the cycle after that.
- Back-to-back tlp_valid on every cycle is supported. Throughput is 1 TLP/cycle.

## Structure
- Package dll_pkg holds:
  - SEQ_W=12.
  - ACKNAK_NONE/ACKNAK_ACK/ACKNAK_NAK codes, shared with replay_buffer.
  - The FSM state encoding.
- Sub-module seq_window_cmp holds the combinational mod-4096 comparison. Inputs: seq, next. Outputs: in_order, duplicate, ahead.

## Test plan
- Reset, then TLPs seq 0,1,2 good on consecutive cycles, busy_n=1:
  - 3 fwd_valid pulses.
  - With ACK_LAT=16, one acknak=01 with ack_seq=2 arrives 16 cycles after the first.
- Good seq 0, then seq 2 good (ahead), then seq 3 with bad LCRC:
  - A single NAK with ack_seq=0.
  - The second error is silent.
  - A replayed seq 1 clears nak_sched and yields an ACK with ack_seq=1.
- Advance next_rcv_seq to 5, then send duplicate seq 3:
  - No fwd_valid.
  - Immediate ACK with ack_seq=4.
- Wraparound: preload next_rcv_seq to 4095 via 4095 TLPs (or a backdoor), accept seq 4095 then 0:
  - next_rcv_seq=1.
  - ACK carries ack_seq=0.
  - Seq 4094 is then classified duplicate.
- busy_n held 0 for 10 cycles during a NAK:
  - acknak/ack_seq stay stable.
  - A good TLP accepted meanwhile produces an ACK after consumption.
- Coalescing: ACK_COALESCE=4 with 4 good TLPs → ACK issued the cycle after the 4th is sampled, before timer expiry.
- Reset asserted while in SEND_NAK → acknak=00, ack_seq=FFF next cycle.
